// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage between execute and write-back.
// Registers execute results, runs load/store transactions on a req/ack
// data-memory port, inserts bubbles and stalls upstream while a transaction
// is outstanding, and flags transactions that never get acknowledged.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_EX, INS_EX, ALU_result_EX,
//   store_data_EX, WBA_EX           instruction and operands from execute
//   stall_MA                        upstream must hold while a transaction is open
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack   data-memory request/acknowledge port
//   WBA_MA, ALU_result, data,
//   INS_MA                          results to write-back
//   mem_err                         sticky timeout flag
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no transaction open; accepts a new instruction from execute
// ST_WAIT | load/store request outstanding; stall upstream, emit bubbles
module ma_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter logic [15:0] NOP_INS = 16'hF000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_EX,
   input  logic [15:0] INS_EX,
   input  logic [15:0] ALU_result_EX,
   input  logic [15:0] store_data_EX,
   input  logic [2:0]  WBA_EX,
   output logic        stall_MA,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [2:0]  WBA_MA,
   output logic [15:0] ALU_result,
   output logic [15:0] data,
   output logic [15:0] INS_MA,
   output logic        mem_err
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [3:0]  OP_LOAD  = 4'b0111;
   localparam logic [3:0]  OP_STORE = 4'b1000;
   // Terminal count of the wait timer; abort fires when the count sits here
   // with no acknowledge.
   localparam logic [15:0] WAIT_TC  = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt;
   logic [15:0] ins_hold;
   logic [15:0] alu_hold;
   logic [2:0]  wba_hold;

   logic [3:0]  opcode;
   logic        is_mem_op;
   logic        accept_alu;
   logic        accept_mem;
   logic        ack_done;
   logic        time_out;

   assign opcode    = INS_EX[15:12];
   assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
   assign stall_MA  = (state == ST_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept_alu = 1'b0;
      accept_mem = 1'b0;
      ack_done   = 1'b0;
      time_out   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (valid_EX) begin
               if (is_mem_op) begin
                  accept_mem = 1'b1;
                  state_nxt  = ST_WAIT;
               end else begin
                  accept_alu = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            // Acknowledge wins over a timeout landing on the same edge.
            if (mem_ack) begin
               ack_done  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (wait_cnt == WAIT_TC) begin
               time_out  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 16'd0;
      end else if (accept_mem || ack_done || time_out) begin
         wait_cnt <= 16'd0;
      end else if (state == ST_WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // Request side: captured on acceptance, held stable until the
   // transaction closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'd0;
         mem_wdata <= 16'd0;
         ins_hold  <= 16'd0;
         alu_hold  <= 16'd0;
         wba_hold  <= 3'd0;
      end else if (accept_mem) begin
         mem_req   <= 1'b1;
         mem_we    <= (opcode == OP_STORE);
         mem_addr  <= ALU_result_EX;
         mem_wdata <= store_data_EX;
         ins_hold  <= INS_EX;
         alu_hold  <= ALU_result_EX;
         wba_hold  <= WBA_EX;
      end else if (ack_done || time_out) begin
         mem_req   <= 1'b0;
      end
   end

   // Write-back side: a bubble every cycle unless something completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         INS_MA     <= NOP_INS;
         WBA_MA     <= 3'd0;
         ALU_result <= 16'd0;
         data       <= 16'd0;
      end else begin
         INS_MA <= NOP_INS;
         if (accept_alu) begin
            INS_MA     <= INS_EX;
            WBA_MA     <= WBA_EX;
            ALU_result <= ALU_result_EX;
         end else if (ack_done) begin
            INS_MA     <= ins_hold;
            WBA_MA     <= wba_hold;
            ALU_result <= alu_hold;
            if (!mem_we) begin
               data <= mem_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err <= 1'b0;
      end else if (time_out) begin
         mem_err <= 1'b1;
      end
   end

endmodule
